reg_file: RTL and testbench

Multi-entry general-purpose register file for the 8-bit CPU datapath: one synchronous write port and two independent registered read ports (A and B) that feed the ALU operand latches. It is the read-side counterpart of the single-entry load register. Entries are written by the writeback stage; operands are fetched by decode with one-cycle latency and write-to-read bypass.

---
 rtl/cpu_pkg.sv | 9 +
 rtl/reg_file_rd_port.sv | 36 +++
 rtl/reg_file.sv | 52 +++++
 tb/tb_reg_file.sv | 129 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths and register index names for the 8-bit CPU
package cpu_pkg;
    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 2;
    localparam logic [REG_ADDR_W-1:0] R0 = 2'd0;
    localparam logic [REG_ADDR_W-1:0] R1 = 2'd1;
    localparam logic [REG_ADDR_W-1:0] R2 = 2'd2;
    localparam logic [REG_ADDR_W-1:0] R3 = 2'd3;
endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: registered read mux with write-to-read bypass and valid pulse
module reg_file_rd_port #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [DEPTH-1:0][WIDTH-1:0]  entries,
    input  logic                         rd_en,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         rd_valid
);
    logic             w_bypass;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    // a same-edge write to the requested entry must win over the stale stored value
    assign w_bypass = wr_en && (wr_addr == rd_addr);
    assign w_next   = w_bypass ? wr_data : entries[rd_addr];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= rd_en;
            if (rd_en) r_data <= w_next;
        end
    end
    assign rd_data  = r_data;
    assign rd_valid = r_valid;
endmodule

// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH register file, one write port and two registered read ports
module reg_file
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 1 << REG_ADDR_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic              rd_valid_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_valid_b
);
    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_mem <= '0;
        else if (wr_en) r_mem[wr_addr] <= wr_data;
    end
    reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_port_a (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .entries  (r_mem),
        .rd_en    (rd_en_a),
        .rd_addr  (rd_addr_a),
        .rd_data  (rd_data_a),
        .rd_valid (rd_valid_a)
    );
    reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_port_b (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .entries  (r_mem),
        .rd_en    (rd_en_b),
        .rd_addr  (rd_addr_b),
        .rd_data  (rd_data_b),
        .rd_valid (rd_valid_b)
    );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: table-driven directed check of reg_file plus async-reset sequence
module tb_reg_file;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_en_a = 1'b0;
    logic [1:0] rd_addr_a = '0;
    logic [7:0] rd_data_a;
    logic       rd_valid_a;
    logic       rd_en_b = 1'b0;
    logic [1:0] rd_addr_b = '0;
    logic [7:0] rd_data_b;
    logic       rd_valid_b;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       we;
        logic [1:0] wa;
        logic [7:0] wd;
        logic       ea;
        logic [1:0] aa;
        logic       eb;
        logic [1:0] ab;
        logic [7:0] xa;
        logic       xva;
        logic [7:0] xb;
        logic       xvb;
    } vec_t;
    vec_t v [21];

    reg_file dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic apply(input int i);
        @(negedge clk);
        wr_en = v[i].we; wr_addr = v[i].wa; wr_data = v[i].wd;
        rd_en_a = v[i].ea; rd_addr_a = v[i].aa;
        rd_en_b = v[i].eb; rd_addr_b = v[i].ab;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d data_a", i), rd_data_a, v[i].xa);
        chk($sformatf("v%0d valid_a", i), {7'd0, rd_valid_a}, {7'd0, v[i].xva});
        chk($sformatf("v%0d data_b", i), rd_data_b, v[i].xb);
        chk($sformatf("v%0d valid_b", i), {7'd0, rd_valid_b}, {7'd0, v[i].xvb});
    endtask

    initial begin
        //        we  wa    wd     ea  aa    eb  ab    xa     xva  xb     xvb
        v[0]  = '{1'b1, 2'd1, 8'hAA, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0};
        v[1]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b0, 2'd0, 8'hAA, 1'b1, 8'h00, 1'b0};
        v[2]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 8'hAA, 1'b0, 8'h00, 1'b0};
        v[3]  = '{1'b1, 2'd2, 8'h11, 1'b0, 2'd0, 1'b0, 2'd0, 8'hAA, 1'b0, 8'h00, 1'b0};
        v[4]  = '{1'b1, 2'd2, 8'hCC, 1'b1, 2'd2, 1'b1, 2'd2, 8'hCC, 1'b1, 8'hCC, 1'b1};
        v[5]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0, 2'd0, 8'hCC, 1'b1, 8'hCC, 1'b0};
        v[6]  = '{1'b0, 2'd3, 8'hFF, 1'b0, 2'd0, 1'b0, 2'd0, 8'hCC, 1'b0, 8'hCC, 1'b0};
        v[7]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0, 2'd0, 8'h00, 1'b1, 8'hCC, 1'b0};
        v[8]  = '{1'b1, 2'd0, 8'h01, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 8'hCC, 1'b0};
        v[9]  = '{1'b1, 2'd3, 8'h80, 1'b0, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 8'hCC, 1'b0};
        v[10] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b1, 2'd3, 8'h01, 1'b1, 8'h80, 1'b1};
        v[11] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 8'h01, 1'b0, 8'h80, 1'b0};
        v[12] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0, 2'd0, 8'h01, 1'b1, 8'h80, 1'b0};
        v[13] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b0, 2'd0, 8'hAA, 1'b1, 8'h80, 1'b0};
        v[14] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0, 2'd0, 8'hCC, 1'b1, 8'h80, 1'b0};
        v[15] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0, 2'd0, 8'h80, 1'b1, 8'h80, 1'b0};
        v[16] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 2'd0, 8'h80, 1'b0, 8'h80, 1'b0};
        // after the mid-run reset every entry must read back as zero
        v[17] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b1, 2'd3, 8'h00, 1'b1, 8'h00, 1'b1};
        v[18] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, 2'd2, 8'h00, 1'b1, 8'h00, 1'b1};
        v[19] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, 2'd1, 8'h00, 1'b1, 8'h00, 1'b1};
        v[20] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b1, 2'd0, 8'h00, 1'b1, 8'h00, 1'b1};

        #12;
        chk("rst data_a", rd_data_a, 8'h00);
        chk("rst valid_a", {7'd0, rd_valid_a}, 8'h00);
        chk("rst data_b", rd_data_b, 8'h00);
        chk("rst valid_b", {7'd0, rd_valid_b}, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) apply(i);

        // request reads, then pull reset low between edges
        @(negedge clk);
        rd_en_a = 1'b1; rd_addr_a = 2'd1; rd_en_b = 1'b1; rd_addr_b = 2'd3;
        @(posedge clk);
        #1;
        chk("pre-rst valid_a", {7'd0, rd_valid_a}, 8'h01);
        chk("pre-rst data_b", rd_data_b, 8'h80);
        #2;
        reset = 1'b0;
        #1;
        chk("async data_a", rd_data_a, 8'h00);
        chk("async valid_a", {7'd0, rd_valid_a}, 8'h00);
        chk("async data_b", rd_data_b, 8'h00);
        chk("async valid_b", {7'd0, rd_valid_b}, 8'h00);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h55;
        rd_en_a = 1'b1; rd_addr_a = 2'd1; rd_en_b = 1'b0;
        @(posedge clk);
        #1;
        chk("in-rst valid_a", {7'd0, rd_valid_a}, 8'h00);
        chk("in-rst data_a", rd_data_a, 8'h00);
        @(negedge clk);
        wr_en = 1'b0; rd_en_a = 1'b0;
        reset = 1'b1;

        for (int i = 17; i < 21; i++) apply(i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
